// File: rtl/cpu_opcodes_pkg.sv
// cpu_opcodes_pkg: ALU opcode constants, issue-controller state encoding and opcode classification.
package cpu_opcodes_pkg;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_NOR  = 5'b01110;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t SETTLE = 2'd1;
    localparam state_t WB_LO  = 2'd2;
    localparam state_t WB_HI  = 2'd3;

    typedef struct packed {
        logic legal;
        logic wide;
    } op_info_t;

    function automatic op_info_t op_info(input logic [4:0] op);
        op_info_t info;
        info.legal = op inside {OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHR, OP_SHL, OP_SHRA,
                                OP_ROR, OP_ROL, OP_AND, OP_OR, OP_NEG, OP_XOR, OP_NOR, OP_NOT};
        info.wide  = op == OP_MUL || op == OP_DIV;
        return info;
    endfunction
endpackage

// File: rtl/settle_counter.sv
// settle_counter: loadable down-counter that stops at zero; done rises one cycle after reaching zero.
module settle_counter #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] count_q, count_d;
    logic         done_q, done_d;

    // done is registered so the ALU result gets one full settled cycle before capture
    always_comb begin
        count_d = load ? load_val : (en && count_q != '0) ? count_q - W'(1) : count_q;
        done_d  = !load && en && count_q == '0;
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: holds one request on the ALU inputs for its settle time, then returns the result in 32-bit beats.
module alu_issue_ctrl
    import cpu_opcodes_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_opcode,
    input  logic [63:0] alu_c,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic        wb_hi,
    output logic        wb_last,
    output logic        err_illegal,
    output logic        busy
);
    localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
    localparam int CW      = MAX_LAT > 1 ? $clog2(MAX_LAT) : 1;

    state_t        state_q, state_d;
    logic [31:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [4:0]    alu_opcode_q, alu_opcode_d;
    logic [63:0]   z_q, z_d;
    logic          wide_q, wide_d;
    logic          err_q, err_d;
    op_info_t      req_info;
    logic          accept, done;
    logic [CW-1:0] load_val;

    assign req_info = op_info(req_opcode);
    assign accept   = state_q == IDLE && req_valid;
    assign load_val = !req_info.wide ? '0 : req_opcode == OP_MUL ? CW'(MUL_LAT - 1) : CW'(DIV_LAT - 1);

    settle_counter #(.W(CW)) u_settle (
        .clock    (clock),
        .clear    (clear),
        .load     (accept),
        .load_val (load_val),
        .en       (state_q == SETTLE),
        .done     (done)
    );

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        z_d          = z_q;
        wide_d       = wide_q;
        err_d        = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                alu_a_d      = req_a;
                alu_b_d      = req_b;
                alu_opcode_d = req_info.legal ? req_opcode : OP_NOP;
                wide_d       = req_info.wide;
                err_d        = !req_info.legal;
                state_d      = req_info.legal && req_opcode != OP_NOP ? SETTLE : IDLE;
            end
            SETTLE: if (done) begin
                z_d     = alu_c;
                state_d = WB_LO;
            end
            WB_LO: if (wb_ready) state_d = wide_q ? WB_HI : IDLE;
            default: if (wb_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= OP_NOP;
            z_q          <= '0;
            wide_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            z_q          <= z_d;
            wide_q       <= wide_d;
            err_q        <= err_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = alu_opcode_q;
    assign req_ready   = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign wb_valid    = state_q == WB_LO || state_q == WB_HI;
    assign wb_hi       = state_q == WB_HI;
    assign wb_last     = state_q == WB_HI || (state_q == WB_LO && !wide_q);
    assign wb_data     = state_q == WB_LO ? z_q[31:0] : state_q == WB_HI ? z_q[63:32] : 32'h0;
    assign err_illegal = err_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vector table, multi-cycle corner sequences and randomized traffic against a beat-queue model.
module tb_alu_issue_ctrl;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;
    localparam logic [4:0] NOP = 5'b11010, ADD = 5'b00011, SUB = 5'b00100, MUL = 5'b10000;
    localparam logic [4:0] DIV = 5'b01111, SHR = 5'b01001, SHL = 5'b01011, SHRA = 5'b01010;
    localparam logic [4:0] ROR = 5'b00111, ROL = 5'b01000, AND = 5'b00101, OR = 5'b00110;
    localparam logic [4:0] NEG = 5'b10001, XOR = 5'b01101, NOR = 5'b01110, NOT = 5'b10010;
    localparam logic [4:0] LEGAL [16] = '{NOP, ADD, SUB, MUL, DIV, SHR, SHL, SHRA,
                                          ROR, ROL, AND, OR, NEG, XOR, NOR, NOT};

    logic        clk = 1'b0, clear = 1'b0, req_valid = 1'b0, wb_ready = 1'b1;
    logic [4:0]  req_opcode = NOP;
    logic [31:0] req_a = '0, req_b = '0;
    logic        req_ready, wb_valid, wb_hi, wb_last, err_illegal, busy;
    logic [31:0] alu_a, alu_b, wb_data;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_c;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clock(clk), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_c(alu_c), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_hi(wb_hi), .wb_last(wb_last), .err_illegal(err_illegal), .busy(busy)
    );

    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] t;
        logic [31:0] r;
        r = '0;
        case (op)
            ADD:  r = a + b;
            SUB:  r = a - b;
            MUL:  return 64'(a) * 64'(b);
            DIV:  return b == 0 ? 64'h0 : {a % b, a / b};
            SHR:  r = a >> b[4:0];
            SHL:  r = a << b[4:0];
            SHRA: r = $signed(a) >>> b[4:0];
            ROR:  begin t = {a, a} >> b[4:0]; r = t[31:0]; end
            ROL:  begin t = {a, a} << b[4:0]; r = t[63:32]; end
            AND:  r = a & b;
            OR:   r = a | b;
            NEG:  r = 32'h0 - a;
            XOR:  r = a ^ b;
            NOR:  r = ~(a | b);
            NOT:  r = ~a;
            default: r = '0;
        endcase
        return {32'h0, r};
    endfunction

    function automatic bit is_legal(input logic [4:0] op);
        foreach (LEGAL[i]) if (LEGAL[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int lat_of(input logic [4:0] op);
        return op == MUL ? MUL_LAT : op == DIV ? DIV_LAT : 1;
    endfunction

    // environment ALU answers whatever the controller presents
    assign alu_c = alu_fn(alu_opcode, alu_a, alu_b);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: remaining beats of the operation in flight; due = edge after which the beat must be visible
    typedef struct {
        logic [31:0] data;
        logic        hi;
        logic        last;
        int          due;
    } beat_t;
    beat_t       q[$];
    logic [31:0] beat_log[$];
    logic [31:0] a_exp = '0, b_exp = '0;
    logic [4:0]  op_exp = NOP;
    logic        err_exp = 1'b0, exp_valid = 1'b0;
    int          cyc = 0;
    bit          armed = 1'b0;

    always @(posedge clk) begin
        logic [63:0] z;
        bit pre_ready;
        cyc++;
        if (!clear) begin
            q.delete();
            a_exp = '0; b_exp = '0; op_exp = NOP; err_exp = 1'b0;
        end else begin
            pre_ready = q.size() == 0;
            err_exp = 1'b0;
            if (exp_valid && wb_ready) begin
                beat_log.push_back(q[0].data);
                void'(q.pop_front());
                if (q.size() > 0) q[0].due = cyc;
            end
            if (pre_ready && req_valid) begin
                a_exp = req_a;
                b_exp = req_b;
                if (!is_legal(req_opcode)) begin
                    err_exp = 1'b1;
                    op_exp = NOP;
                end else begin
                    op_exp = req_opcode;
                    z = alu_fn(req_opcode, req_a, req_b);
                    if (req_opcode == MUL || req_opcode == DIV) begin
                        q.push_back('{z[31:0], 1'b0, 1'b0, cyc + lat_of(req_opcode) + 1});
                        q.push_back('{z[63:32], 1'b1, 1'b1, 0});
                    end else if (req_opcode != NOP)
                        q.push_back('{z[31:0], 1'b0, 1'b1, cyc + lat_of(req_opcode) + 1});
                end
            end
        end
        exp_valid = q.size() > 0 && cyc >= q[0].due;
    end

    always @(negedge clk) if (armed) begin
        chk("req_ready", req_ready, q.size() == 0);
        chk("busy", busy, q.size() != 0);
        chk("wb_valid", wb_valid, exp_valid);
        chk("err_illegal", err_illegal, err_exp);
        chk("alu_opcode", alu_opcode, op_exp);
        chk("alu_a", alu_a, a_exp);
        chk("alu_b", alu_b, b_exp);
        if (exp_valid && wb_valid) begin
            chk("wb_data", wb_data, q[0].data);
            chk("wb_hi", wb_hi, q[0].hi);
            chk("wb_last", wb_last, q[0].last);
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
        end
        chk(name, ok, 1'b1);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, lo, hi;
        int          n;
    } vec_t;
    vec_t vecs[9];
    vec_t bb[3];

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d0;
        logic        got, nop_seen;
        int          idx, nbeats;
        vecs[0] = '{ADD,  32'd5,          32'd7,          32'h0000000C, 32'h0, 1};
        vecs[1] = '{MUL,  32'h00010000,   32'h00010000,   32'h00000000, 32'h1, 2};
        vecs[2] = '{SUB,  32'd10,         32'd3,          32'h00000007, 32'h0, 1};
        vecs[3] = '{AND,  32'h0000F0F0,   32'h0000FF00,   32'h0000F000, 32'h0, 1};
        vecs[4] = '{DIV,  32'd100,        32'd7,          32'd14,       32'd2, 2};
        vecs[5] = '{XOR,  32'hFF00FF00,   32'h0FF00FF0,   32'hF0F0F0F0, 32'h0, 1};
        vecs[6] = '{ROL,  32'h80000001,   32'd4,          32'h00000018, 32'h0, 1};
        vecs[7] = '{SHRA, 32'h80000000,   32'd4,          32'hF8000000, 32'h0, 1};
        vecs[8] = '{NEG,  32'd5,          32'd0,          32'hFFFFFFFB, 32'h0, 1};
        bb[0] = '{SUB, 32'd10, 32'd3, 32'h7, 32'h0, 1};
        bb[1] = '{NOP, 32'd1, 32'd2, 32'h0, 32'h0, 0};
        bb[2] = '{AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'h0, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_hi", wb_hi, 1'b0);
        chk("rst_wb_last", wb_last, 1'b0);
        chk("rst_err", err_illegal, 1'b0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_alu_opcode", alu_opcode, NOP);
        clear = 1'b1;
        armed = 1'b1;

        foreach (vecs[i]) begin
            beat_log.delete();
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle("vec_idle");
            chk("vec_beats", beat_log.size(), vecs[i].n);
            if (beat_log.size() > 0) chk("vec_lo", beat_log[0], vecs[i].lo);
            if (beat_log.size() > 1) chk("vec_hi", beat_log[1], vecs[i].hi);
        end

        // backpressure on the low beat of a mul while another request waits
        wb_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_opcode = MUL; req_a = 32'd3; req_b = 32'd5;
        @(negedge clk);
        req_opcode = ADD; req_a = 32'd1; req_b = 32'd1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = wb_valid;
        end
        chk("bp_reach_wb", got, 1'b1);
        d0 = wb_data;
        chk("bp_lo_data", d0, 32'd15);
        chk("bp_lo_last", wb_last, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("bp_data_hold", wb_data, d0);
            chk("bp_hi_hold", wb_hi, 1'b0);
            chk("bp_last_hold", wb_last, 1'b0);
            chk("bp_ready_low", req_ready, 1'b0);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("bp_hi_beat", wb_hi, 1'b1);
        chk("bp_hi_data", wb_data, 32'h0);
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        wait_idle("bp_idle");

        // illegal opcode
        issue(5'b11111, 32'd9, 32'd9);
        chk("ill_err", err_illegal, 1'b1);
        chk("ill_op", alu_opcode, NOP);
        chk("ill_ready", req_ready, 1'b1);
        chk("ill_valid", wb_valid, 1'b0);
        @(negedge clk);
        chk("ill_err_pulse", err_illegal, 1'b0);
        chk("ill_ready2", req_ready, 1'b1);

        // reset in the third cycle of a div
        issue(DIV, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", wb_valid, 1'b0);
        chk("mid_rst_op", alu_opcode, NOP);
        nbeats = 0;
        repeat (20) begin
            @(negedge clk);
            if (wb_valid) nbeats++;
        end
        chk("mid_rst_no_beat", nbeats, 0);

        // back-to-back sub, nop, and with req_valid held high
        beat_log.delete();
        idx = 0;
        nop_seen = 1'b0;
        for (int i = 0; i < 60 && idx < 3; i++) begin
            @(negedge clk);
            if (nop_seen) begin
                chk("bb_nop_ready", req_ready, 1'b1);
                chk("bb_nop_no_beat", wb_valid, 1'b0);
                nop_seen = 1'b0;
            end
            req_valid = 1'b1; req_opcode = bb[idx].op; req_a = bb[idx].a; req_b = bb[idx].b;
            got = req_ready;
            @(posedge clk);
            if (got) begin
                nop_seen = bb[idx].op == NOP;
                idx++;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("bb_accepts", idx, 3);
        wait_idle("bb_idle");
        chk("bb_beats", beat_log.size(), 2);
        if (beat_log.size() > 0) chk("bb_beat0", beat_log[0], 32'h7);
        if (beat_log.size() > 1) chk("bb_beat1", beat_log[1], 32'h0000F000);

        // randomized traffic, backpressure and occasional reset
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            wb_ready   = $urandom_range(0, 3) != 0;
            req_valid  = $urandom_range(0, 2) != 0;
            req_opcode = $urandom_range(0, 7) == 0 ? 5'($urandom) : LEGAL[$urandom_range(0, 15)];
            req_a      = $urandom;
            req_b      = $urandom_range(0, 1) != 0 ? $urandom : $urandom_range(0, 40);
            clear      = $urandom_range(0, 199) != 0;
        end
        @(negedge clk);
        clear = 1'b1; req_valid = 1'b0; wb_ready = 1'b1;
        wait_idle("rand_idle");
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
